// File: rtl/reg_file_pkg.sv
// Shared definitions for the MIPS register file slice.
// Optional feature macro: REG_FILE_BYPASS_EN (undefined by default; define it
// to forward same-cycle write data onto the read ports).
package reg_file_pkg;

    // Default geometry of the general-purpose register file
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;

    // Architecturally special register indices
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/reg_file_if.sv
// Register-file bus: two read ports plus the write-back write port.
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
);

    logic [ADDR_W-1:0] A1;
    logic [ADDR_W-1:0] A2;
    logic [ADDR_W-1:0] A3;
    logic [DATA_W-1:0] WD;
    logic              RegWrite;
    logic [DATA_W-1:0] RD1;
    logic [DATA_W-1:0] RD2;

    // Datapath side: issues read indices and write-back traffic
    modport master (
        output A1, A2, A3, WD, RegWrite,
        input  RD1, RD2
    );

    // Register file side
    modport slave (
        input  A1, A2, A3, WD, RegWrite,
        output RD1, RD2
    );

endinterface

// File: rtl/reg_file_read_port.sv
// Combinational read port: forces $0 to zero and, when REG_FILE_BYPASS_EN is
// defined, forwards the in-flight write data on an index match.
module reg_read_port
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
`ifdef REG_FILE_BYPASS_EN
    input  logic              i_fwd_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
`endif
    output logic [DATA_W-1:0] o_rd
);

    // Select array data, optional forwarded data, and $0 override (highest priority)
    always_comb begin
        o_rd = i_data;
`ifdef REG_FILE_BYPASS_EN
        if (i_fwd_en && (i_addr == i_wr_addr)) begin
            o_rd = i_wr_data;
        end
`endif
        if (i_addr == ADDR_W'(REG_ZERO)) begin
            o_rd = '0;
        end
    end

endmodule

// File: rtl/reg_file.sv
// 32 x 32-bit MIPS register file: two asynchronous read ports, one synchronous
// write port, synchronous active-high reset. Optional macro REG_FILE_BYPASS_EN
// enables same-cycle write-to-read forwarding.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic             clk,
    input  logic             reset,
    reg_file_if.slave        bus
);

    logic [DATA_W-1:0] r_regs [2**ADDR_W];
    logic              w_wr_en;
    logic [DATA_W-1:0] w_rd1_raw;
    logic [DATA_W-1:0] w_rd2_raw;

    assign w_wr_en   = bus.RegWrite && (bus.A3 != ADDR_W'(REG_ZERO));
    assign w_rd1_raw = r_regs[bus.A1];
    assign w_rd2_raw = r_regs[bus.A2];

    // Storage update: reset clears every entry and overrides any pending write
    always_ff @(posedge clk) begin
        if (reset) begin
            r_regs <= '{default: '0};
        end else if (w_wr_en) begin
            r_regs[bus.A3] <= bus.WD;
        end
    end

`ifdef REG_FILE_BYPASS_EN
    logic w_fwd_en;
    // Forwarding only when the write will actually land this edge
    assign w_fwd_en = w_wr_en && !reset;
`endif

    reg_read_port #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_rd1 (
        .i_addr    (bus.A1),
        .i_data    (w_rd1_raw),
`ifdef REG_FILE_BYPASS_EN
        .i_fwd_en  (w_fwd_en),
        .i_wr_addr (bus.A3),
        .i_wr_data (bus.WD),
`endif
        .o_rd      (bus.RD1)
    );

    reg_read_port #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_rd2 (
        .i_addr    (bus.A2),
        .i_data    (w_rd2_raw),
`ifdef REG_FILE_BYPASS_EN
        .i_fwd_en  (w_fwd_en),
        .i_wr_addr (bus.A3),
        .i_wr_data (bus.WD),
`endif
        .o_rd      (bus.RD2)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios followed by random
// traffic, compared against a plain array model of the register file.
module tb_reg_file;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [31:0] model [32];

    reg_file_if bus ();

    reg_file dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected read value from the model for index a under the current inputs
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
        if (!reset && bus.RegWrite && (bus.A3 == a)) return bus.WD;
`endif
        return model[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs (called just after a falling edge), settle, compare reads
    task automatic drive(input string tag, input logic rst, input logic we,
                         input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] a3, input logic [31:0] wd,
                         input bit do_chk);
        reset        = rst;
        bus.RegWrite = we;
        bus.A1       = a1;
        bus.A2       = a2;
        bus.A3       = a3;
        bus.WD       = wd;
        #1;
        if (do_chk) begin
            chk({tag, "_rd1"}, bus.RD1, exp_rd(a1));
            chk({tag, "_rd2"}, bus.RD2, exp_rd(a2));
        end
    endtask

    // Clock edge: advance the model by the architectural rules, return at negedge
    task automatic step();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (bus.RegWrite && bus.A3 != 5'd0) begin
            model[bus.A3] = bus.WD;
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        reset = 1'b1;
        bus.RegWrite = 1'b0;
        bus.A1 = '0; bus.A2 = '0; bus.A3 = '0; bus.WD = '0;
        @(negedge clk);

        // 1: reset two cycles (with a write attempt), then sweep all indices
        drive("rst0", 1'b1, 1'b1, 5'd4, 5'd4, 5'd4, 32'hFFFF_FFFF, 1'b0);
        step();
        drive("rst1", 1'b1, 1'b1, 5'd4, 5'd5, 5'd4, 32'hFFFF_FFFF, 1'b1);
        step();
        for (int a = 0; a < 32; a++) begin
            drive("sweep", 1'b0, 1'b0, 5'(a), 5'(31 - a), 5'd0, 32'h0, 1'b1);
            chk("sweep_zero", bus.RD1 | bus.RD2, 32'h0);
        end

        // 2: simple write then read on both ports
        drive("t2w", 1'b0, 1'b1, 5'd0, 5'd0, 5'd8, 32'hDEAD_BEEF, 1'b1);
        step();
        drive("t2r", 1'b0, 1'b0, 5'd8, 5'd8, 5'd0, 32'h0, 1'b1);
        chk("t2_rd1_const", bus.RD1, 32'hDEAD_BEEF);
        chk("t2_rd2_const", bus.RD2, 32'hDEAD_BEEF);

        // 3: write to $0 is dropped, $0 reads zero even while targeted
        drive("t3w", 1'b0, 1'b1, 5'd0, 5'd8, 5'd0, 32'h1234_5678, 1'b1);
        chk("t3_zero_during", bus.RD1, 32'h0);
        step();
        drive("t3r", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1);
        chk("t3_zero_after", bus.RD1, 32'h0);

        // 4: same-cycle read/write of $ra
        drive("t4w", 1'b0, 1'b1, 5'd31, 5'd31, 5'd31, 32'h0040_0008, 1'b1);
`ifdef REG_FILE_BYPASS_EN
        chk("t4_before_edge", bus.RD1, 32'h0040_0008);
`else
        chk("t4_before_edge", bus.RD1, 32'h0);
`endif
        step();
        drive("t4r", 1'b0, 1'b0, 5'd31, 5'd8, 5'd0, 32'h0, 1'b1);
        chk("t4_after_edge", bus.RD1, 32'h0040_0008);

        // 5: reset wins over a simultaneous write
        drive("t5w", 1'b0, 1'b1, 5'd9, 5'd9, 5'd9, 32'hA5A5_A5A5, 1'b1);
        step();
        drive("t5rst", 1'b1, 1'b1, 5'd9, 5'd31, 5'd9, 32'h1, 1'b1);
        chk("t5_held_before_rst", bus.RD1, 32'hA5A5_A5A5);
        step();
        drive("t5r", 1'b0, 1'b0, 5'd9, 5'd8, 5'd0, 32'h0, 1'b1);
        chk("t5_cleared", bus.RD1, 32'h0);
        chk("t5_other_cleared", bus.RD2, 32'h0);

        // 6: RegWrite gates the write
        drive("t6n", 1'b0, 1'b0, 5'd3, 5'd3, 5'd3, 32'h7, 1'b1);
        step();
        drive("t6c", 1'b0, 1'b0, 5'd3, 5'd3, 5'd0, 32'h0, 1'b1);
        chk("t6_no_write", bus.RD1, 32'h0);
        drive("t6w", 1'b0, 1'b1, 5'd3, 5'd3, 5'd3, 32'h7, 1'b1);
        step();
        drive("t6r", 1'b0, 1'b0, 5'd3, 5'd3, 5'd0, 32'h0, 1'b1);
        chk("t6_written", bus.RD1, 32'h7);

        // Reset held over several cycles with writes attempted every cycle
        for (int i = 0; i < 3; i++) begin
            drive("rsthold", 1'b1, 1'b1, 5'(i + 1), 5'd3, 5'(i + 1), $urandom, 1'b1);
            step();
        end
        for (int a = 1; a < 32; a += 5) begin
            drive("rsthold_chk", 1'b0, 1'b0, 5'(a), 5'(a), 5'd0, 32'h0, 1'b1);
        end

        // Random traffic, occasionally reset, often reading the written index
        for (int n = 0; n < 400; n++) begin
            logic       r_rst;
            logic       r_we;
            logic [4:0] r_a1, r_a2, r_a3;
            r_rst = ($urandom_range(0, 24) == 0);
            r_we  = 1'($urandom_range(0, 1));
            r_a3  = 5'($urandom_range(0, 31));
            r_a1  = ($urandom_range(0, 3) == 0) ? r_a3 : 5'($urandom_range(0, 31));
            r_a2  = ($urandom_range(0, 3) == 0) ? r_a3 : 5'($urandom_range(0, 31));
            drive("rand", r_rst, r_we, r_a1, r_a2, r_a3, $urandom, 1'b1);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
